// File: rtl/cmd_ram_if.sv
// Command/read-data bundle between the SPI slave front end and cmd_ram.
// master = SPI side (drives commands, accepts read data), slave = RAM side.
interface cmd_ram_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH+1:0] din;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [DATA_WIDTH-1:0] dout;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  err;

    modport master (output din, rx_valid, tx_ready, input rx_ready, dout, tx_valid, err);
    modport slave  (input din, rx_valid, tx_ready, output rx_ready, dout, tx_valid, err);
endinterface

// File: rtl/cmd_ram.sv
// Single-port command RAM: opcode-driven writes and reads with separate
// write/read pointers, optional burst auto-increment and a sticky range error.
module cmd_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int AUTO_INC   = 1
) (
    input logic      clk,
    input logic      rst,
    cmd_ram_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, TX} state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(MEM_DEPTH - 1);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  tx_valid_q, err_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [1:0]            op;
    logic [ADDR_WIDTH-1:0] payload;
    logic                  accept, wr_ok, rd_ok, wr_en;

    // Wrap at MEM_DEPTH-1 rather than at the pointer width, so non-power-of-2 depths burst cleanly.
    function automatic logic [ADDR_WIDTH-1:0] inc(input logic [ADDR_WIDTH-1:0] p);
        if (AUTO_INC == 0) return p;
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign op           = bus.din[ADDR_WIDTH+1:ADDR_WIDTH];
    assign payload      = bus.din[ADDR_WIDTH-1:0];
    assign bus.rx_ready = (state == IDLE);
    assign accept       = bus.rx_valid && bus.rx_ready;
    assign wr_ok        = {1'b0, wr_addr} < DEPTH;
    assign rd_ok        = {1'b0, rd_addr} < DEPTH;
    assign wr_en        = accept && (op == 2'b01) && wr_ok;
    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.err      = err_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && op == 2'b11) state_nxt = RD;
            RD:      state_nxt = TX;
            TX:      if (bus.tx_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr    <= '0;
            rd_addr    <= '0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                case (op)
                    2'b00:   wr_addr <= payload;
                    2'b01:   if (wr_ok) wr_addr <= inc(wr_addr);
                             else       err_q   <= 1'b1;
                    2'b10:   rd_addr <= payload;
                    default: ;
                endcase
            end
            if (state == RD) begin
                tx_valid_q <= 1'b1;
                if (rd_ok) begin
                    dout_q  <= mem[rd_addr];
                    rd_addr <= inc(rd_addr);
                end else begin
                    dout_q <= '0;
                    err_q  <= 1'b1;
                end
            end else if (state == TX && bus.tx_ready) begin
                tx_valid_q <= 1'b0;
            end
        end
    end

    // Memory has no reset; reset only blocks a coincident write.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem[wr_addr] <= payload[DATA_WIDTH-1:0];
    end
endmodule

// File: tb/tb_cmd_ram.sv
// Directed bench for cmd_ram: three parameter sets share one stimulus driver,
// read data checked against a scoreboard queue filled when reads are issued.
module tb_cmd_ram;
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] din;
    logic       rx_valid, tx_ready;
    int         sel;
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] sb[$];

    logic [7:0] obs_dout;
    logic       obs_tx_valid, obs_rx_ready, obs_err;

    always #5 clk = ~clk;

    cmd_ram_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus0 ();
    cmd_ram_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus1 ();
    cmd_ram_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus2 ();

    assign bus0.din = din;  assign bus0.rx_valid = rx_valid && sel == 0;  assign bus0.tx_ready = tx_ready;
    assign bus1.din = din;  assign bus1.rx_valid = rx_valid && sel == 1;  assign bus1.tx_ready = tx_ready;
    assign bus2.din = din;  assign bus2.rx_valid = rx_valid && sel == 2;  assign bus2.tx_ready = tx_ready;

    cmd_ram #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    cmd_ram #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(200), .AUTO_INC(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    cmd_ram #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always_comb begin
        obs_dout = bus0.dout; obs_tx_valid = bus0.tx_valid; obs_rx_ready = bus0.rx_ready; obs_err = bus0.err;
        if (sel == 1) begin
            obs_dout = bus1.dout; obs_tx_valid = bus1.tx_valid; obs_rx_ready = bus1.rx_ready; obs_err = bus1.err;
        end else if (sel == 2) begin
            obs_dout = bus2.dout; obs_tx_valid = bus2.tx_valid; obs_rx_ready = bus2.rx_ready; obs_err = bus2.err;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One command per call; returns at the negedge after the accepting edge.
    task automatic cmd(input logic [1:0] op, input logic [7:0] pl);
        @(negedge clk);
        din      = {op, pl};
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Issue opcode 11 with tx_ready high; check data at handshake and busy length.
    task automatic do_read(input logic [7:0] exp, input int exp_low);
        int low  = 0;
        bit done = 0;
        sb.push_back(exp);
        cmd(2'b11, 8'h00);
        for (int i = 0; i < 20; i++) begin
            if (!obs_rx_ready) low++;
            if (obs_tx_valid && tx_ready && sb.size() > 0) chk("rd_dout", obs_dout, sb.pop_front());
            if (obs_rx_ready) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rd_done", done, 1);
        chk("rd_busy", low, exp_low);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        sel = 0; rst = 1'b1; din = '0; rx_valid = 1'b0; tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_tx_valid", obs_tx_valid, 0);
        chk("rst_dout", obs_dout, 0);
        chk("rst_err", obs_err, 0);
        chk("rst_rx_ready", obs_rx_ready, 1);

        // Burst write, then burst read
        cmd(2'b00, 8'h10); cmd(2'b01, 8'hA5); cmd(2'b01, 8'h5A);
        cmd(2'b10, 8'h10);
        do_read(8'hA5, 2);
        do_read(8'h5A, 2);

        // Pointer wrap at the top of a full-depth memory
        cmd(2'b00, 8'hFF); cmd(2'b01, 8'h11); cmd(2'b01, 8'h22); cmd(2'b01, 8'h33);
        cmd(2'b10, 8'hFF);
        do_read(8'h11, 2);
        do_read(8'h22, 2);
        do_read(8'h33, 2);
        chk("wrap_err", obs_err, 0);

        // Backpressure with ignored commands arriving while busy
        tx_ready = 1'b0;
        cmd(2'b10, 8'h10);
        sb.push_back(8'hA5);
        cmd(2'b11, 8'h00);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_tx_valid", obs_tx_valid, 1);
            chk("bp_dout", obs_dout, sb[0]);
            chk("bp_rx_ready", obs_rx_ready, 0);
            din      = {2'b01, 8'hEE};
            rx_valid = (i % 2 == 0);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        chk("bp_dout_hs", obs_dout, sb.pop_front());
        @(negedge clk);
        chk("bp_tx_drop", obs_tx_valid, 0);
        chk("bp_rx_back", obs_rx_ready, 1);
        cmd(2'b01, 8'h44); cmd(2'b10, 8'h02);
        do_read(8'h44, 2);

        // Depth 200: out-of-range write/read, wrap at 199
        sel = 1;
        cmd(2'b00, 8'hC8); cmd(2'b01, 8'h77);
        chk("oor_err", obs_err, 1);
        chk("oor_wr_addr", dut1.wr_addr, 8'hC8);
        cmd(2'b10, 8'hC8);
        do_read(8'h00, 2);
        chk("oor_rd_addr", dut1.rd_addr, 8'hC8);
        cmd(2'b00, 8'hC7); cmd(2'b01, 8'h66); cmd(2'b01, 8'h67);
        chk("d200_wrap_wr", dut1.wr_addr, 8'h01);
        cmd(2'b10, 8'hC7);
        do_read(8'h66, 2);
        do_read(8'h67, 2);
        chk("oor_err_sticky", obs_err, 1);

        // No auto-increment
        sel = 2;
        cmd(2'b00, 8'h05); cmd(2'b01, 8'h3C); cmd(2'b10, 8'h05);
        do_read(8'h3C, 2);
        do_read(8'h3C, 2);
        chk("noinc_rd_addr", dut2.rd_addr, 8'h05);
        chk("noinc_wr_addr", dut2.wr_addr, 8'h05);

        // Reset in TX aborts the read, memory survives
        sel = 1;
        tx_ready = 1'b0;
        cmd(2'b10, 8'hC7);
        cmd(2'b11, 8'h00);
        @(negedge clk);
        chk("rtx_pre_valid", obs_tx_valid, 1);
        chk("rtx_pre_dout", obs_dout, 8'h66);
        rst = 1'b1;
        @(negedge clk);
        chk("rtx_tx_valid", obs_tx_valid, 0);
        chk("rtx_dout", obs_dout, 0);
        chk("rtx_rx_ready", obs_rx_ready, 1);
        chk("rtx_err", obs_err, 0);
        rst = 1'b0;
        tx_ready = 1'b1;
        cmd(2'b10, 8'hC7);
        do_read(8'h66, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
